scaler_linear_h: RTL and testbench

Horizontal linear-interpolation scaler placed directly upstream of the vertical scaler in the scaler2 pipeline. It stores each input line in a ping-pong line buffer, then regenerates the line at a programmable horizontal step. Each output pixel is a 2-tap linear blend of neighbouring input pixels. The output stream uses the same strobe convention the vertical stage consumes: hs with de marks the first pixel of a line, and vs with de marks the first pixel of a frame.

---
 rtl/scaler_linear_h.sv | 232 +++++++++++++++++++++++
 tb/tb_scaler_linear_h.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_linear_h.sv
`default_nettype none
// scaler_linear_h: horizontal 2-tap linear-interpolation scaler with ping-pong line buffers.
// Rev 1.0 - initial release
module scaler_linear_h #(
  parameter int PIXEL_WIDTH      = 12,
  parameter int COE_WIDTH        = 10,
  parameter int PIXEL_STEP       = 4096,
  parameter int LINE_IN_SIZE_MAX = 1024,
  parameter int SPARSE_OUT       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            scale_step,
  input  logic [15:0]            line_in_size,
  input  logic [15:0]            line_out_size,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   err_o
);
  localparam int S     = $clog2(PIXEL_STEP);
  localparam int AW    = $clog2(LINE_IN_SIZE_MAX);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (SPARSE_OUT > 0) ? $clog2(SPARSE_OUT + 1) : 1;
  localparam int MW    = PIXEL_WIDTH + COE_WIDTH + 1;
  localparam int SW    = MW + 1;
  localparam logic [SW-1:0]      RND     = SW'(1) << (COE_WIDTH - 1);
  localparam logic [COE_WIDTH:0] COE_ONE = {1'b1, {COE_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_PRM  = 2'd1,
    GEN_LINE = 2'd2
  } gen_state_t;

  logic                   in_de, in_hs, in_vs;
  logic [PIXEL_WIDTH-1:0] in_di;
  logic                   wr_open, wr_sel, wr_vs;
  logic [15:0]            wr_addr, waddr;
  logic [1:0]             buf_full, buf_fs;
  logic [15:0]            buf_step [2];
  logic [15:0]            buf_size [2];
  logic                   line_open, line_drop, line_short, wr_en, commit, commit_fs;

  gen_state_t             state;
  logic                   rd_sel, cur_fs, issue, line_done;
  logic [31:0]            pos, int_pos, lim, idx, idx1;
  logic [15:0]            out_cnt, cur_step, cur_size;
  logic [CW-1:0]          cnt_sp;
  logic [COE_WIDTH-1:0]   frac, frac1;

  logic [PIXEL_WIDTH-1:0] ram_a [DEPTH*2];
  logic [PIXEL_WIDTH-1:0] ram_b [DEPTH*2];
  logic [PIXEL_WIDTH-1:0] rd_a, rd_b;
  logic                   v1, h1, f1, v2, h2, f2, v3, h3, f3;
  logic [COE_WIDTH:0]     coe0;
  logic [MW-1:0]          m0, m1;
  logic [SW-1:0]          sum;
  logic                   unused_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_de <= 1'b0;
      in_hs <= 1'b0;
      in_vs <= 1'b0;
      in_di <= '0;
    end else begin
      in_de <= de_i;
      in_hs <= de_i & hs_i;
      in_vs <= de_i & vs_i;
      in_di <= di_i;
    end
  end

  // A new line may only open in a free buffer; an hs while a line is open restarts it in place.
  always_comb begin
    line_open  = in_de & in_hs & ~buf_full[wr_sel];
    line_drop  = in_de & in_hs &  buf_full[wr_sel];
    line_short = in_de & in_hs & wr_open;
    waddr      = line_open ? 16'd0 : wr_addr;
    wr_en      = (line_open | (in_de & ~in_hs & wr_open)) && (waddr < line_in_size);
    commit     = wr_en && (waddr == line_in_size - 16'd1);
    commit_fs  = line_open ? in_vs : wr_vs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_open     <= 1'b0;
      wr_sel      <= 1'b0;
      wr_vs       <= 1'b0;
      wr_addr     <= 16'd0;
      err_o       <= 1'b0;
      buf_fs      <= 2'b00;
      buf_step[0] <= 16'd0;
      buf_step[1] <= 16'd0;
      buf_size[0] <= 16'd1;
      buf_size[1] <= 16'd1;
    end else begin
      if (line_short | line_drop) err_o <= 1'b1;
      if (commit) begin
        wr_open          <= 1'b0;
        wr_sel           <= ~wr_sel;
        buf_fs[wr_sel]   <= commit_fs;
        buf_step[wr_sel] <= scale_step;
        buf_size[wr_sel] <= line_in_size;
      end else if (line_open) begin
        wr_open <= 1'b1;
        wr_addr <= 16'd1;
        wr_vs   <= in_vs;
      end else if (line_drop) begin
        wr_open <= 1'b0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + 16'd1;
      end
    end
  end

  // Commit and release never target the same buffer: commit needs it free, release needs it full.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!rst_n)
        buf_full[b] <= 1'b0;
      else if (commit && (wr_sel == 1'(b)))
        buf_full[b] <= 1'b1;
      else if (line_done && (rd_sel == 1'(b)))
        buf_full[b] <= 1'b0;
    end
  end

  always_comb begin
    issue     = (state == GEN_LINE) && (cnt_sp == '0);
    line_done = issue && (out_cnt == line_out_size - 16'd1);
    int_pos   = pos >> S;
    lim       = {16'd0, cur_size - 16'd1};
    idx       = (int_pos > lim) ? lim : int_pos;
    idx1      = (idx >= lim) ? lim : idx + 32'd1;
    frac      = pos[S-1 -: COE_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= GEN_IDLE;
      rd_sel   <= 1'b0;
      pos      <= 32'd0;
      out_cnt  <= 16'd0;
      cnt_sp   <= '0;
      cur_fs   <= 1'b0;
      cur_step <= 16'd0;
      cur_size <= 16'd1;
    end else begin
      case (state)
        GEN_IDLE: if (buf_full[rd_sel]) state <= GEN_PRM;
        GEN_PRM: begin
          pos      <= 32'd0;
          out_cnt  <= 16'd0;
          cnt_sp   <= '0;
          cur_fs   <= buf_fs[rd_sel];
          cur_step <= buf_step[rd_sel];
          cur_size <= buf_size[rd_sel];
          state    <= GEN_LINE;
        end
        GEN_LINE: begin
          if (issue) begin
            pos     <= pos + {16'd0, cur_step};
            out_cnt <= out_cnt + 16'd1;
            cnt_sp  <= CW'(SPARSE_OUT);
            if (line_done) begin
              rd_sel <= ~rd_sel;
              state  <= GEN_IDLE;
            end
          end else begin
            cnt_sp <= cnt_sp - CW'(1);
          end
        end
        default: state <= GEN_IDLE;
      endcase
    end
  end

  // Two copies of the ping-pong storage give independent read ports for both taps.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_a[{wr_sel, waddr[AW-1:0]}] <= in_di;
      ram_b[{wr_sel, waddr[AW-1:0]}] <= in_di;
    end
    rd_a <= ram_a[{rd_sel, idx[AW-1:0]}];
    rd_b <= ram_b[{rd_sel, idx1[AW-1:0]}];
  end

  always_comb coe0 = COE_ONE - {1'b0, frac1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {v1, h1, f1, v2, h2, f2, v3, h3, f3} <= '0;
      frac1 <= '0;
      m0    <= '0;
      m1    <= '0;
      sum   <= '0;
      do_o  <= '0;
      de_o  <= 1'b0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
    end else begin
      v1    <= issue;
      h1    <= issue && (out_cnt == 16'd0);
      f1    <= issue && (out_cnt == 16'd0) && cur_fs;
      frac1 <= frac;
      v2    <= v1;
      h2    <= h1;
      f2    <= f1;
      m0    <= MW'(rd_a) * MW'(coe0);
      m1    <= MW'(rd_b) * MW'(frac1);
      v3    <= v2;
      h3    <= h2;
      f3    <= f2;
      sum   <= {1'b0, m0} + {1'b0, m1} + RND;
      de_o  <= v3;
      hs_o  <= h3;
      vs_o  <= f3;
      do_o  <= v3 ? sum[COE_WIDTH +: PIXEL_WIDTH] : '0;
    end
  end

  assign unused_bits = ^{idx[31:AW], idx1[31:AW], sum[COE_WIDTH-1:0], sum[SW-1]};

endmodule
`default_nettype wire

// File: tb/tb_scaler_linear_h.sv
`default_nettype none
// tb_scaler_linear_h: randomized scoreboard bench for scaler_linear_h (SPARSE_OUT 0 and 2 instances).
`timescale 1ns/1ps
module tb_scaler_linear_h;
  localparam int PW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [15:0]   scale_step, line_in_size, line_out_size;
  logic [PW-1:0] di_i;
  logic          de_i, hs_i, vs_i;
  logic [PW-1:0] do0, do2;
  logic          de0, hs0, vs0, err0, de2, hs2, vs2, err2;

  scaler_linear_h #(.SPARSE_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .scale_step(scale_step), .line_in_size(line_in_size),
    .line_out_size(line_out_size), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0), .err_o(err0));

  scaler_linear_h #(.SPARSE_OUT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .scale_step(scale_step), .line_in_size(line_in_size),
    .line_out_size(line_out_size), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do2), .de_o(de2), .hs_o(hs2), .vs_o(vs2), .err_o(err2));

  typedef struct packed {
    logic [PW-1:0] d;
    logic          hs;
    logic          vs;
  } exp_t;

  exp_t          q0[$];
  exp_t          q2[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_in_cyc = 0;
  int            last_de[2];
  bit            lat_chk = 1'b0;
  logic [PW-1:0] pix [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: output k samples the input line at k*step/4096 with a 2-tap blend.
  function automatic void push_model(input int step, input int insz, input int outsz, input bit vs);
    longint pos;
    int     idx, idx1, frac, v;
    exp_t   e;
    for (int k = 0; k < outsz; k++) begin
      pos  = longint'(k) * step;
      idx  = int'(pos / 4096);
      if (idx > insz - 1) idx = insz - 1;
      idx1 = (idx + 1 > insz - 1) ? insz - 1 : idx + 1;
      frac = int'((pos % 4096) / 4);
      v    = (int'(pix[idx]) * (1024 - frac) + int'(pix[idx1]) * frac + 512) / 1024;
      e.d  = v[PW-1:0];
      e.hs = (k == 0);
      e.vs = (k == 0) && vs;
      q0.push_back(e);
      q2.push_back(e);
    end
  endfunction

  task automatic mon(input int id, input logic de, input logic hs, input logic vs,
                     input logic [PW-1:0] d, input int sp);
    exp_t e;
    if (rst_n !== 1'b1) return;
    if (!de) begin
      if (hs || vs) begin
        errors++;
        $display("FAIL strobe_without_de dut%0d hs=%0b vs=%0b required 0", sp, hs, vs);
      end
      return;
    end
    checks++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q2.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_output dut%0d do=%0d at cycle %0d, none expected", sp, d, cyc);
      return;
    end
    e = (id == 0) ? q0.pop_front() : q2.pop_front();
    if ({d, hs, vs} !== e) begin
      errors++;
      $display("FAIL pixel dut%0d got do=%0d hs=%0b vs=%0b expected do=%0d hs=%0b vs=%0b",
               sp, d, hs, vs, e.d, e.hs, e.vs);
    end
    if (hs && lat_chk) begin
      checks++;
      if (cyc - last_in_cyc != 8) begin
        errors++;
        $display("FAIL latency dut%0d got %0d cycles required 8", sp, cyc - last_in_cyc);
      end
    end
    if (!hs) begin
      checks++;
      if (cyc - last_de[id] != sp + 1) begin
        errors++;
        $display("FAIL spacing dut%0d got %0d cycles required %0d", sp, cyc - last_de[id], sp + 1);
      end
    end
    last_de[id] = cyc;
  endtask

  always @(negedge clk) mon(0, de0, hs0, vs0, do0, 0);
  always @(negedge clk) mon(1, de2, hs2, vs2, do2, 2);

  task automatic send_line(input int nsend, input int step, input int insz, input int outsz,
                           input bit vs, input bit expect_out);
    @(negedge clk);
    scale_step    = 16'(step);
    line_in_size  = 16'(insz);
    line_out_size = 16'(outsz);
    if (expect_out) push_model(step, insz, outsz, vs);
    for (int i = 0; i < nsend; i++) begin
      de_i = 1'b1;
      hs_i = (i == 0);
      vs_i = vs && (i == 0);
      di_i = pix[i];
      if (i == nsend - 1) last_in_cyc = cyc;
      if (i != nsend - 1) @(negedge clk);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    de_i = 1'b0;
    hs_i = 1'b0;
    vs_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q2.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() > 0 || q2.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending dut0=%0d dut2=%0d required 0", q0.size(), q2.size());
      q0.delete();
      q2.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({do0, de0, hs0, vs0, err0, do2, de2, hs2, vs2, err2} !== '0) begin
      errors++;
      $display("FAIL %s dut0 do=%0d de=%0b hs=%0b vs=%0b err=%0b dut2 do=%0d de=%0b hs=%0b vs=%0b err=%0b required all 0",
               name, do0, de0, hs0, vs0, err0, do2, de2, hs2, vs2, err2);
    end
  endtask

  task automatic chk_err(input string name, input logic req);
    checks++;
    if (err0 !== req || err2 !== req) begin
      errors++;
      $display("FAIL %s err dut0=%0b dut2=%0b required %0b", name, err0, err2, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");
    q0.delete();
    q2.delete();
  endtask

  initial begin
    int step, insz, outsz;
    rst_n = 1'b0;
    scale_step = 16'd4096;
    line_in_size = 16'd8;
    line_out_size = 16'd8;
    di_i = '0;
    de_i = 1'b0;
    hs_i = 1'b0;
    vs_i = 1'b0;
    do_reset();
    lat_chk = 1'b1;

    for (int i = 0; i < 8; i++) pix[i] = PW'(100 * i);
    send_line(8, 4096, 8, 8, 1'b1, 1'b1); idle_in(); drain(300);

    pix[0] = 12'd0; pix[1] = 12'd400; pix[2] = 12'd800; pix[3] = 12'd1200;
    send_line(4, 2048, 4, 8, 1'b0, 1'b1); idle_in(); drain(300);

    for (int i = 0; i < 8; i++) pix[i] = PW'(i);
    send_line(8, 8192, 8, 4, 1'b1, 1'b1); idle_in(); drain(300);

    pix[0] = 12'd0; pix[1] = 12'd1000;
    send_line(2, 1024, 2, 4, 1'b0, 1'b1); idle_in(); drain(300);

    for (int i = 0; i < 16; i++) pix[i] = 12'hFFF;
    send_line(16, int'($urandom_range(256, 12000)), 16, 20, 1'b0, 1'b1); idle_in(); drain(300);
    chk_err("no_error_so_far", 1'b0);

    for (int n = 0; n < 8; n++) begin
      insz  = int'($urandom_range(1, 16));
      outsz = int'($urandom_range(1, 24));
      step  = int'($urandom_range(256, 12000));
      for (int i = 0; i < 16; i++) pix[i] = PW'($urandom_range(0, 4095));
      send_line(insz, step, insz, outsz, 1'($urandom_range(0, 1)), 1'b1);
      idle_in();
      drain(400);
    end

    // Short line: the 5-pixel fragment is discarded, the following full line is output.
    for (int i = 0; i < 8; i++) pix[i] = PW'($urandom_range(0, 4095));
    send_line(5, 3000, 8, 8, 1'b0, 1'b0);
    send_line(8, 3000, 8, 8, 1'b0, 1'b1);
    idle_in();
    drain(300);
    chk_err("short_line", 1'b1);

    do_reset();
    lat_chk = 1'b0;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) pix[i] = PW'($urandom_range(0, 4095));
      send_line(8, 4096, 8, 100, n == 0, n < 2);
    end
    idle_in();
    repeat (5) @(negedge clk);
    chk_err("overrun_set", 1'b1);
    drain(1500);
    chk_err("overrun_held", 1'b1);

    do_reset();
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) pix[i] = PW'($urandom_range(0, 4095));
    send_line(8, 4096, 8, 100, 1'b1, 1'b1);
    idle_in();
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("mid_line_reset");
    q0.delete();
    q2.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) pix[i] = PW'($urandom_range(0, 4095));
    send_line(8, 3000, 8, 8, 1'b1, 1'b1);
    idle_in();
    drain(300);
    chk_err("after_reset_clean", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
